edge_event_queue: RTL and testbench

Downstream consumer of the edge detector. Takes the per-bit one-cycle edge pulses (one bit per button/switch) and turns them into an ordered stream of event indices, buffered in a small FIFO with a valid/ready output. Software-facing logic (MMIO button register, CPU polling) pops one event per handshake. Pulses are never lost silently: a re-trigger on a still-pending bit is coalesced and counted as a drop.

---
 rtl/edge_event_queue.sv | 123 ++++++++++++
 tb/tb_edge_event_queue.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_queue.sv
// Edge-pulse event queue: latches per-bit edge pulses as pending, arbitrates the
// lowest pending index into a FIFO, and counts re-triggers that were coalesced.
module edge_event_queue #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 8,
    parameter int DROP_W = 8,
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  edge_pulse,
    output logic              evt_valid,
    output logic [IDX_W-1:0]  evt_index,
    input  logic              evt_ready,
    output logic [CNT_W-1:0]  count,
    output logic [DROP_W-1:0] drop_cnt,
    input  logic              drop_clr
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int POP_W = $clog2(WIDTH + 1);
    localparam int SUM_W = DROP_W + POP_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    logic [WIDTH-1:0]  pending_q, pending_d;
    logic [IDX_W-1:0]  mem_q [DEPTH];
    logic [IDX_W-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    logic              push;
    logic              pop;
    logic [IDX_W-1:0]  sel_idx;
    logic [WIDTH-1:0]  sel_mask;
    logic [WIDTH-1:0]  push_mask;
    logic [WIDTH-1:0]  drop_bits;
    logic [POP_W-1:0]  drop_n;
    logic [SUM_W-1:0]  drop_sum;

    always_comb begin
        sel_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
        sel_mask = pending_q & (~pending_q + WIDTH'(1));

        // A full queue blocks the push even when a pop frees a slot this cycle.
        push      = (count_q != FULL_CNT) && (pending_q != '0);
        pop       = (count_q != '0) && evt_ready;
        push_mask = push ? sel_mask : '0;

        // A pulse on the bit being enqueued is a fresh event, not a drop.
        drop_bits = edge_pulse & pending_q & ~push_mask;
        drop_n    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            drop_n = drop_n + POP_W'(drop_bits[i]);
        end
        drop_sum = SUM_W'(drop_cnt_q) + SUM_W'(drop_n);

        pending_d = (pending_q & ~push_mask) | edge_pulse;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = sel_idx;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end

        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        if (drop_clr) begin
            drop_cnt_d = '0;
        end else if (drop_sum > SUM_W'(DROP_MAX)) begin
            drop_cnt_d = DROP_MAX;
        end else begin
            drop_cnt_d = drop_sum[DROP_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            pending_q  <= pending_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign evt_valid = (count_q != '0);
    assign evt_index = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_edge_event_queue.sv
// Directed and scoreboarded checks for edge_event_queue, with a second
// instance built with a 2-bit drop counter to exercise saturation.
module tb_edge_event_queue;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [3:0] pulse = 4'hF;
    logic       ready = 1'b0;
    logic       clr = 1'b0;
    logic       valid;
    logic [1:0] index;
    logic [3:0] count;
    logic [7:0] drop;

    logic [3:0] s_pulse = 4'h0;
    logic       s_ready = 1'b0;
    logic       s_clr = 1'b0;
    logic       s_valid;
    logic [1:0] s_index;
    logic [3:0] s_count;
    logic [1:0] s_drop;

    int checks = 0;
    int errors = 0;

    int         m_q[$];
    logic [3:0] m_pend = 4'h0;
    int         m_drop = 0;

    always #5 clk = ~clk;

    edge_event_queue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .edge_pulse (pulse),
        .evt_valid  (valid),
        .evt_index  (index),
        .evt_ready  (ready),
        .count      (count),
        .drop_cnt   (drop),
        .drop_clr   (clr)
    );

    edge_event_queue #(.DROP_W(2)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .edge_pulse (s_pulse),
        .evt_valid  (s_valid),
        .evt_index  (s_index),
        .evt_ready  (s_ready),
        .count      (s_count),
        .drop_cnt   (s_drop),
        .drop_clr   (s_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] p, input logic r);
        pulse = p;
        ready = r;
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference behaviour for one clock edge, using the inputs currently applied.
    task automatic model_step();
        bit         do_pop;
        bit         do_push;
        int         sel;
        logic [3:0] cleared;
        logic [3:0] dropped;
        int         n;
        do_pop  = (m_q.size() > 0) && ready;
        do_push = (m_q.size() < 8) && (m_pend != 4'h0);
        sel = 0;
        for (int i = 3; i >= 0; i--) begin
            if (m_pend[i]) sel = i;
        end
        cleared = do_push ? (4'h1 << sel) : 4'h0;
        dropped = pulse & m_pend & ~cleared;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (dropped[i]) n++;
        end
        if (do_pop) void'(m_q.pop_front());
        if (do_push) m_q.push_back(sel);
        if (clr) m_drop = 0;
        else m_drop = (m_drop + n > 255) ? 255 : m_drop + n;
        m_pend = (m_pend & ~cleared) | pulse;
    endtask

    initial begin
        int exp_order[8];
        int pulses_sent;
        int pops_seen;
        int guard;

        // Reset held with every pulse asserted: nothing may be captured.
        tick();
        tick();
        checkOutput("reset_valid", 32'(valid), 32'd0);
        checkOutput("reset_count", 32'(count), 32'd0);
        checkOutput("reset_drop", 32'(drop), 32'd0);
        checkOutput("reset_index", 32'(index), 32'd0);
        pulse = 4'h0;
        rst_n = 1'b1;
        tick();
        tick();
        checkOutput("post_reset_count", 32'(count), 32'd0);

        // Single event latency.
        applyStimulus(4'b0100, 1'b0);
        checkOutput("lat_n1_valid", 32'(valid), 32'd0);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("lat_n2_valid", 32'(valid), 32'd1);
        checkOutput("lat_n2_index", 32'(index), 32'd2);
        checkOutput("lat_n2_count", 32'(count), 32'd1);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("lat_pop_count", 32'(count), 32'd0);
        checkOutput("lat_pop_valid", 32'(valid), 32'd0);

        // Simultaneous pulses drain lowest index first.
        applyStimulus(4'b1011, 1'b1);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("sim_first", 32'(index), 32'd0);
        checkOutput("sim_count", 32'(count), 32'd1);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("sim_second", 32'(index), 32'd1);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("sim_third", 32'(index), 32'd3);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("sim_empty", 32'(count), 32'd0);
        checkOutput("sim_drop", 32'(drop), 32'd0);

        // Fill to full, then coalesce a re-trigger on a pending bit.
        applyStimulus(4'hF, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(4'h0, 1'b0);
        applyStimulus(4'hF, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(4'h0, 1'b0);
        checkOutput("full_count", 32'(count), 32'd8);
        checkOutput("full_head", 32'(index), 32'd0);
        checkOutput("full_drop", 32'(drop), 32'd0);
        applyStimulus(4'b0010, 1'b0);
        applyStimulus(4'b0010, 1'b0);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("coal_count", 32'(count), 32'd8);
        checkOutput("coal_drop", 32'(drop), 32'd1);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("full_no_passthru", 32'(count), 32'd7);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("coal_refill", 32'(count), 32'd8);
        exp_order = '{1, 2, 3, 0, 1, 2, 3, 1};
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("drain_%0d", i), 32'(index), 32'(exp_order[i]));
            tick();
        end
        ready = 1'b0;
        checkOutput("drain_empty", 32'(count), 32'd0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checkOutput("clr_drop", 32'(drop), 32'd0);

        // Random stress against the scoreboard model.
        m_q.delete();
        m_pend = 4'h0;
        m_drop = 0;
        pulses_sent = 0;
        pops_seen = 0;
        guard = 0;
        while (pulses_sent < 80 && guard < 2000) begin
            guard++;
            if ($urandom_range(0, 1) == 1) begin
                pulse = 4'($urandom_range(1, 15));
                pulses_sent++;
            end else begin
                pulse = 4'h0;
            end
            ready = 1'($urandom_range(0, 1));
            if (valid && ready) pops_seen++;
            model_step();
            tick();
            checkOutput("stress_valid", 32'(valid), 32'(m_q.size() != 0));
            checkOutput("stress_count", 32'(count), 32'(m_q.size()));
            checkOutput("stress_count_max", 32'(count <= 4'd8), 32'd1);
            checkOutput("stress_drop", 32'(drop), 32'(m_drop));
            if (m_q.size() != 0) checkOutput("stress_index", 32'(index), 32'(m_q[0]));
        end
        for (int i = 0; i < 20; i++) begin
            pulse = 4'h0;
            ready = 1'b1;
            if (valid) pops_seen++;
            model_step();
            tick();
            checkOutput("stress_drain_count", 32'(count), 32'(m_q.size()));
            if (m_q.size() != 0) checkOutput("stress_drain_index", 32'(index), 32'(m_q[0]));
        end
        checkOutput("stress_final_empty", 32'(count), 32'd0);
        checkOutput("stress_wraps", 32'(pops_seen >= 32), 32'd1);
        ready = 1'b0;

        // Saturating drop counter on the 2-bit instance.
        s_pulse = 4'b1110;
        tick();
        s_pulse = 4'b1110;
        tick();
        checkOutput("sat_drop_2", 32'(s_drop), 32'd2);
        s_pulse = 4'b1100;
        tick();
        checkOutput("sat_drop_sat", 32'(s_drop), 32'd3);
        s_pulse = 4'b1000;
        tick();
        checkOutput("sat_drop_hold", 32'(s_drop), 32'd3);
        s_pulse = 4'b1000;
        s_clr = 1'b1;
        tick();
        checkOutput("sat_clr", 32'(s_drop), 32'd0);
        s_pulse = 4'b0000;
        s_clr = 1'b0;
        tick();
        checkOutput("sat_after_clr", 32'(s_drop), 32'd0);
        checkOutput("sat_count", 32'(s_count), 32'd5);
        checkOutput("sat_head", 32'(s_index), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
